xge_pkt_rx_reader: RTL and testbench

- Hardware client for the MAC packet-receive interface: the reader side of pkt_rx_avail/pkt_rx_ren/pkt_rx_*.
- Pulls frames out of the MAC RX FIFO, checks framing and length, and forwards 64-bit words to a downstream valid/ready stream through a small skid buffer.
- Keeps frame, error and last-length statistics.
- Sits between the MAC pkt_rx port and on-chip packet consumers, in the clk_156m25 domain.

---
 rtl/xge_rx_pkg.sv | 20 ++
 rtl/xge_rx_skid_fifo.sv | 52 +++++
 rtl/xge_pkt_rx_reader.sv | 136 +++++++++++++
 tb/tb_xge_pkt_rx_reader.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/xge_rx_pkg.sv
// Shared types and constants for the MAC packet-receive reader.
package xge_rx_pkg;

  localparam int BYTES_PER_WORD = 8;
  localparam int LEN_W          = 16;

  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
    logic        err;
  } rx_word_t;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rx_state_e;

endpackage

// File: rtl/xge_rx_skid_fifo.sv
// First-word-fall-through skid buffer of rx words; reports free entries so the
// reader can throttle the MAC.
module xge_rx_skid_fifo
  import xge_rx_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk_156m25,
  input  logic           reset_156m25_n,
  input  logic           wr_en,
  input  rx_word_t       wr_word,
  input  logic           rd_en,
  output logic           rd_valid,
  output rx_word_t       rd_word,
  output logic [PTR_W:0] free
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  rx_word_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_rd;

  assign rd_valid = (count != '0);
  assign do_rd    = rd_en && rd_valid;
  assign free     = DEPTH_C - count;
  // Gate the head word so the stream reads all-zero whenever it is empty.
  assign rd_word  = rd_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk_156m25) begin
    if (wr_en) mem[wr_ptr] <= wr_word;
  end

  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PTR_W{1'b0}}, wr_en} - {{PTR_W{1'b0}}, do_rd};
    end
  end

  a_no_overflow: assert property (@(posedge clk_156m25) disable iff (!reset_156m25_n)
    !(wr_en && (count == DEPTH_C) && !do_rd));

endmodule

// File: rtl/xge_pkt_rx_reader.sv
// MAC pkt_rx reader: pulls frames, checks framing/length, forwards words to a
// valid/ready stream and keeps frame statistics.
//   state | meaning
//   IDLE  | no read in progress; waits for a queued frame and buffer room
//   READ  | issuing pkt_rx_ren until the eop word arrives
module xge_pkt_rx_reader
  import xge_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MIN_LEN    = 64,
  parameter int MAX_LEN    = 1518
) (
  input  logic             clk_156m25,
  input  logic             reset_156m25_n,
  input  logic             pkt_rx_avail,
  output logic             pkt_rx_ren,
  input  logic             pkt_rx_val,
  input  logic [63:0]      pkt_rx_data,
  input  logic             pkt_rx_sop,
  input  logic             pkt_rx_eop,
  input  logic [2:0]       pkt_rx_mod,
  input  logic             pkt_rx_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic             out_sop,
  output logic             out_eop,
  output logic [2:0]       out_mod,
  output logic             out_err,
  output logic             frame_done,
  output logic [31:0]      frame_cnt,
  output logic [31:0]      err_cnt,
  output logic [LEN_W-1:0] last_len
);

  localparam int          CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [16:0] LEN_SAT = '1;
  localparam logic [16:0] MIN_L   = 17'(MIN_LEN);
  localparam logic [16:0] MAX_L   = 17'(MAX_LEN);

  rx_state_e        state;
  logic [CNT_W-1:0] free;
  logic             room;
  logic             in_frame;
  logic             err_lat;
  logic [16:0]      len;
  logic             acc, drop_nosop, drop_idle, wr_en, eop_wr;
  logic [3:0]       add;
  logic [16:0]      len_base, len_new;
  logic [17:0]      len_sum;
  logic             err_eff, frame_err;
  rx_word_t         wr_word, rd_word;

  assign room = (free >= CNT_W'(2));

  always_comb begin
    acc        = pkt_rx_val && (state == READ);
    drop_nosop = acc && !pkt_rx_sop && !in_frame;
    drop_idle  = pkt_rx_val && (state == IDLE);
    wr_en      = acc && !drop_nosop;
    eop_wr     = wr_en && pkt_rx_eop;
    add        = (pkt_rx_eop && pkt_rx_mod != 3'd0) ? {1'b0, pkt_rx_mod} : 4'(BYTES_PER_WORD);
    len_base   = pkt_rx_sop ? '0 : len;
    len_sum    = {1'b0, len_base} + 18'(add);
    len_new    = len_sum[17] ? LEN_SAT : len_sum[16:0];
    // A sop arriving mid-frame restarts the length and taints the new frame.
    err_eff    = pkt_rx_sop ? in_frame : err_lat;
    frame_err  = pkt_rx_err | err_eff | (len_new < MIN_L) | (len_new > MAX_L);
    wr_word    = '{data: pkt_rx_data, sop: pkt_rx_sop, eop: pkt_rx_eop,
                   mod: pkt_rx_mod, err: eop_wr & frame_err};
    pkt_rx_ren = (state == READ) && room && !(pkt_rx_val && pkt_rx_eop);
  end

  xge_rx_skid_fifo #(.DEPTH(FIFO_DEPTH)) u_skid (
    .clk_156m25     (clk_156m25),
    .reset_156m25_n (reset_156m25_n),
    .wr_en          (wr_en),
    .wr_word        (wr_word),
    .rd_en          (out_ready),
    .rd_valid       (out_valid),
    .rd_word        (rd_word),
    .free           (free)
  );

  assign out_data = rd_word.data;
  assign out_sop  = rd_word.sop;
  assign out_eop  = rd_word.eop;
  assign out_mod  = rd_word.mod;
  assign out_err  = rd_word.err;

  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      state      <= IDLE;
      in_frame   <= 1'b0;
      err_lat    <= 1'b0;
      len        <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      err_cnt    <= '0;
      last_len   <= '0;
    end else begin
      frame_done <= eop_wr;
      unique case (state)
        IDLE:    if (pkt_rx_avail && room) state <= READ;
        READ:    if (pkt_rx_val && pkt_rx_eop) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (wr_en) begin
        if (pkt_rx_eop) begin
          in_frame  <= 1'b0;
          err_lat   <= 1'b0;
          len       <= '0;
          frame_cnt <= frame_cnt + 32'd1;
          if (frame_err) err_cnt <= err_cnt + 32'd1;
          last_len  <= len_new[16] ? 16'hFFFF : len_new[15:0];
        end else begin
          in_frame <= 1'b1;
          err_lat  <= err_eff;
          len      <= len_new;
        end
      end else if (drop_nosop) begin
        // Headless frame: keep reading it, but it is already in error.
        if (pkt_rx_eop) begin
          err_cnt <= err_cnt + 32'd1;
        end else begin
          in_frame <= 1'b1;
          err_lat  <= 1'b1;
          len      <= '0;
        end
      end else if (drop_idle) begin
        err_cnt <= err_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_xge_pkt_rx_reader.sv
// Directed bench: MAC pkt_rx model, stream scoreboard and statistics checks.
module tb_xge_pkt_rx_reader;
  import xge_rx_pkg::*;

  logic        clk_156m25 = 1'b0;
  logic        reset_156m25_n = 1'b0;
  logic        pkt_rx_avail = 1'b0;
  logic        pkt_rx_ren;
  logic        pkt_rx_val = 1'b0;
  logic [63:0] pkt_rx_data = '0;
  logic        pkt_rx_sop = 1'b0;
  logic        pkt_rx_eop = 1'b0;
  logic [2:0]  pkt_rx_mod = '0;
  logic        pkt_rx_err = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_data;
  logic        out_sop, out_eop, out_err;
  logic [2:0]  out_mod;
  logic        frame_done;
  logic [31:0] frame_cnt, err_cnt;
  logic [15:0] last_len;

  xge_pkt_rx_reader dut (
    .clk_156m25(clk_156m25), .reset_156m25_n(reset_156m25_n),
    .pkt_rx_avail(pkt_rx_avail), .pkt_rx_ren(pkt_rx_ren), .pkt_rx_val(pkt_rx_val),
    .pkt_rx_data(pkt_rx_data), .pkt_rx_sop(pkt_rx_sop), .pkt_rx_eop(pkt_rx_eop),
    .pkt_rx_mod(pkt_rx_mod), .pkt_rx_err(pkt_rx_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sop(out_sop), .out_eop(out_eop), .out_mod(out_mod), .out_err(out_err),
    .frame_done(frame_done), .frame_cnt(frame_cnt), .err_cnt(err_cnt), .last_len(last_len)
  );

  always #3 clk_156m25 = ~clk_156m25;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [69:0] got, input logic [69:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  rx_word_t tx_mem [1024];
  int       tx_count = 0;
  int       rd_idx = 0;
  int       fid = 0;
  bit       mac_flush = 1'b0;
  rx_word_t exp_q [$];

  // MAC model: a ren seen in one cycle returns a word in the next.
  initial begin
    logic ren_q;
    forever begin
      @(negedge clk_156m25);
      ren_q = pkt_rx_ren;
      @(posedge clk_156m25);
      #1;
      if (mac_flush) begin
        rd_idx = tx_count;
        pkt_rx_val = 1'b0;
        mac_flush = 1'b0;
      end else if (ren_q && rd_idx < tx_count) begin
        pkt_rx_val  = 1'b1;
        pkt_rx_data = tx_mem[rd_idx].data;
        pkt_rx_sop  = tx_mem[rd_idx].sop;
        pkt_rx_eop  = tx_mem[rd_idx].eop;
        pkt_rx_mod  = tx_mem[rd_idx].mod;
        pkt_rx_err  = tx_mem[rd_idx].err;
        rd_idx++;
      end else begin
        pkt_rx_val = 1'b0;
      end
      pkt_rx_avail = (rd_idx < tx_count);
    end
  end

  int cyc = 0;
  int fd_cnt = 0;
  bit arm_rearm = 1'b0;
  bit wait_rearm = 1'b0;
  int eop_cyc = 0;

  // Monitor: scoreboard, frame_done pulses, ren behaviour around eop.
  always @(negedge clk_156m25) begin
    cyc++;
    if (frame_done) fd_cnt++;
    if (pkt_rx_val && pkt_rx_eop) chk("ren_at_eop", 70'(pkt_rx_ren), 70'(0));
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("stream_extra", 70'(out_valid), 70'(0));
      else chk("stream_word", {out_data, out_sop, out_eop, out_mod, out_err}, exp_q.pop_front());
    end
    if (wait_rearm && pkt_rx_ren) begin
      chk("rearm_gap", 70'(cyc - eop_cyc), 70'(2));
      wait_rearm = 1'b0;
    end else if (arm_rearm && pkt_rx_val && pkt_rx_eop) begin
      eop_cyc = cyc;
      wait_rearm = 1'b1;
      arm_rearm = 1'b0;
    end
  end

  task automatic push_frame(input int nwords, input logic [2:0] mod,
                            input logic err_in, input logic exp_err);
    rx_word_t w;
    fid++;
    for (int i = 0; i < nwords; i++) begin
      w.data = {8'(fid), 24'(i), 32'($urandom)};
      w.sop  = (i == 0);
      w.eop  = (i == nwords - 1);
      w.mod  = w.eop ? mod : 3'd0;
      w.err  = w.eop ? err_in : 1'b0;
      tx_mem[tx_count] = w;
      tx_count++;
      w.err  = w.eop ? exp_err : 1'b0;
      exp_q.push_back(w);
    end
  endtask

  task automatic wait_drain(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(posedge clk_156m25);
      if (exp_q.size() == 0 && rd_idx == tx_count && !pkt_rx_val) done = 1'b1;
    end
    repeat (3) @(posedge clk_156m25);
    @(negedge clk_156m25);
    chk(tag, 70'(done), 70'(1));
  endtask

  task automatic wait_reads(input int n);
    for (int i = 0; i < 200 && rd_idx < n; i++) @(posedge clk_156m25);
  endtask

  task automatic chk_stats(input string tag, input int fc, input int ec,
                           input int ll, input int fd);
    chk({tag, "_frame_cnt"}, 70'(frame_cnt), 70'(fc));
    chk({tag, "_err_cnt"}, 70'(err_cnt), 70'(ec));
    chk({tag, "_last_len"}, 70'(last_len), 70'(ll));
    chk({tag, "_frame_done"}, 70'(fd_cnt), 70'(fd));
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_out_valid"}, 70'(out_valid), 70'(0));
    chk({tag, "_ren"}, 70'(pkt_rx_ren), 70'(0));
    chk({tag, "_out_word"}, {out_data, out_sop, out_eop, out_mod, out_err}, 70'(0));
    chk({tag, "_frame_done"}, 70'(frame_done), 70'(0));
    chk({tag, "_frame_cnt"}, 70'(frame_cnt), 70'(0));
    chk({tag, "_err_cnt"}, 70'(err_cnt), 70'(0));
    chk({tag, "_last_len"}, 70'(last_len), 70'(0));
  endtask

  initial begin
    int base;
    repeat (3) @(posedge clk_156m25);
    #1 chk_idle_outputs("reset");
    reset_156m25_n = 1'b1;
    repeat (2) @(posedge clk_156m25);

    // 8 words, mod 4: 60 bytes -> runt
    push_frame(8, 3'd4, 1'b0, 1'b1);
    wait_drain("t1_drain");
    chk_stats("t1", 1, 1, 60, 1);

    // 16 words, mod 0: 128 bytes, clean
    push_frame(16, 3'd0, 1'b0, 1'b0);
    wait_drain("t2_drain");
    chk_stats("t2", 2, 1, 128, 2);

    // two 64-byte frames back to back
    arm_rearm = 1'b1;
    push_frame(8, 3'd0, 1'b0, 1'b0);
    push_frame(8, 3'd0, 1'b0, 1'b0);
    wait_drain("t3_drain");
    chk_stats("t3", 4, 1, 64, 4);
    chk("t3_rearm_seen", 70'(wait_rearm | arm_rearm), 70'(0));

    // downstream stall mid-frame
    base = rd_idx;
    push_frame(16, 3'd0, 1'b0, 1'b0);
    wait_reads(base + 3);
    @(posedge clk_156m25);
    #1 out_ready = 1'b0;
    repeat (15) @(posedge clk_156m25);
    @(negedge clk_156m25);
    chk("t4_ren_stalled", 70'(pkt_rx_ren), 70'(0));
    chk("t4_valid_held", 70'(out_valid), 70'(1));
    chk("t4_reads_bounded", 70'(rd_idx - base <= 8), 70'(1));
    repeat (5) @(posedge clk_156m25);
    #1 out_ready = 1'b1;
    wait_drain("t4_drain");
    chk_stats("t4", 5, 1, 128, 5);

    // MAC error on a 100-byte frame, then an oversize 1600-byte frame
    push_frame(13, 3'd4, 1'b1, 1'b1);
    wait_drain("t5a_drain");
    chk_stats("t5a", 6, 2, 100, 6);
    push_frame(200, 3'd0, 1'b0, 1'b1);
    wait_drain("t5b_drain");
    chk_stats("t5b", 7, 3, 1600, 7);

    // reset in the middle of a frame
    base = rd_idx;
    push_frame(10, 3'd0, 1'b0, 1'b0);
    wait_reads(base + 3);
    @(posedge clk_156m25);
    #2;
    reset_156m25_n = 1'b0;
    mac_flush = 1'b1;
    exp_q.delete();
    #1 chk_idle_outputs("t6_rst");
    repeat (3) @(posedge clk_156m25);
    #2 reset_156m25_n = 1'b1;
    fd_cnt = 0;
    repeat (2) @(posedge clk_156m25);
    push_frame(8, 3'd0, 1'b0, 1'b0);
    wait_drain("t6_drain");
    chk_stats("t6", 1, 0, 64, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
